// File: rtl/window_loader.sv
// window_loader
//   Collects an N x N window of pixel words arriving in raster order over a
//   valid/ready stream, then presents the whole window in parallel until the
//   consumer takes it.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin filling a window (honoured in IDLE only)
//   flush      synchronous abort back to IDLE (highest priority)
//   pix_valid  upstream pixel beat valid
//   pix_ready  block accepts a pixel this cycle
//   pix_data   pixel word, row-major raster order
//   win_data   packed window, element (row j, col i) at slot N*j+i
//   win_valid  win_data holds a complete window
//   win_ready  consumer has taken the window
//   wr_row     row index of next slot to be written
//   wr_col     column index of next slot to be written
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; no beats accepted
// FILL  | accepting beats into slot N*wr_row+wr_col
// FULL  | window complete, win_valid high until consumer handshake

module window_loader #(
    parameter int DW = 16,
    parameter int N  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              flush,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DW-1:0]     pix_data,
    output logic [DW*N*N-1:0] win_data,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [2:0]        wr_row,
    output logic [2:0]        wr_col
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(N - 1);

    state_t              state_q, state_d;
    logic [2:0]          row_q, row_d;
    logic [2:0]          col_q, col_d;
    logic [DW*N*N-1:0]   win_q, win_d;
    logic                accept;
    int                  slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= 3'd0;
            col_q   <= 3'd0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        win_d     = win_q;
        pix_ready = (state_q == FILL) && !flush;
        accept    = pix_valid && pix_ready;
        slot      = N * int'(row_q) + int'(col_q);

        if (flush) begin
            state_d = IDLE;
            row_d   = 3'd0;
            col_d   = 3'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) state_d = FILL;
                end
                FILL: begin
                    if (accept) begin
                        win_d[slot*DW +: DW] = pix_data;
                        if (col_q == LAST_IDX) begin
                            col_d = 3'd0;
                            if (row_q == LAST_IDX) begin
                                row_d   = 3'd0;
                                state_d = FULL;
                            end else begin
                                row_d = row_q + 3'd1;
                            end
                        end else begin
                            col_d = col_q + 3'd1;
                        end
                    end
                end
                FULL: begin
                    // Old window stays in win_q and is overwritten slot by slot.
                    if (win_ready) state_d = FILL;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign win_data  = win_q;
    assign win_valid = (state_q == FULL);
    assign wr_row    = row_q;
    assign wr_col    = col_q;

endmodule

// File: tb/tb_window_loader.sv
module tb_window_loader;

    localparam int DW = 16;
    localparam int N  = 7;
    localparam int NN = N * N;
    localparam int WW = DW * NN;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          flush = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [DW-1:0] pix_data = '0;
    logic [WW-1:0] win_data;
    logic          win_valid;
    logic          win_ready = 1'b0;
    logic [2:0]    wr_row;
    logic [2:0]    wr_col;

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural model: beat count into the window plus busy/full flags
    bit            m_busy;
    bit            m_full;
    int            m_k;
    logic [DW-1:0] m_win [NN];

    window_loader #(.DW(DW), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready),
        .wr_row(wr_row), .wr_col(wr_col)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] m_vec();
        logic [WW-1:0] v;
        for (int s = 0; s < NN; s++) v[s*DW +: DW] = m_win[s];
        return v;
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_full = 0;
        m_k    = 0;
        for (int s = 0; s < NN; s++) m_win[s] = '0;
    endtask

    task automatic model_step();
        if (!rst_n) model_reset();
        else if (flush) begin
            m_busy = 0; m_full = 0; m_k = 0;
        end else if (!m_busy) begin
            if (start) m_busy = 1;
        end else if (m_full) begin
            if (win_ready) m_full = 0;
        end else if (pix_valid) begin
            m_win[m_k] = pix_data;
            m_k++;
            if (m_k == NN) begin
                m_k = 0;
                m_full = 1;
            end
        end
    endtask

    task automatic compare();
        logic exp_ready;
        exp_ready = m_busy && !m_full && !flush && rst_n;
        chk("pix_ready", WW'(pix_ready), WW'(exp_ready));
        chk("win_valid", WW'(win_valid), WW'(m_full));
        chk("wr_row", WW'(wr_row), WW'(m_k / N));
        chk("wr_col", WW'(wr_col), WW'(m_k % N));
        chk("win_data", win_data, m_vec());
    endtask

    // inputs are set at the falling edge before calling tick
    task automatic tick();
        #1;
        compare();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_idle();
        start = 0; flush = 0; pix_valid = 0; win_ready = 0;
    endtask

    initial begin
        logic [WW-1:0] full_snap;
        model_reset();
        @(negedge clk);
        tick();
        chk("reset_win_data", win_data, '0);
        rst_n = 1;
        tick();

        // full window with beat k carrying k+1
        start = 1; tick(); start = 0;
        for (int k = 0; k < NN; k++) begin
            pix_valid = 1; pix_data = DW'(k + 1);
            tick();
        end
        pix_valid = 0;
        #1;
        chk("fill_valid_latency", WW'(win_valid), WW'(1'b1));
        chk("slot48", WW'(win_data[48*DW +: DW]), WW'(16'd49));
        chk("slot0", WW'(win_data[0 +: DW]), WW'(16'd1));
        chk("model_slot48", WW'(m_win[48]), WW'(16'd49));
        full_snap = win_data;

        // back-pressure in FULL, with a stray start
        for (int c = 0; c < 10; c++) begin
            pix_valid = 1; win_ready = 0; pix_data = DW'($urandom);
            start = (c == 5);
            tick();
        end
        start = 0;
        #1;
        chk("full_hold_data", win_data, full_snap);
        chk("full_hold_valid", WW'(win_valid), WW'(1'b1));
        pix_valid = 0; win_ready = 1; tick();
        win_ready = 0;
        #1;
        chk("handshake_drop_valid", WW'(win_valid), WW'(1'b0));

        // gapped beats
        for (int i = 0; i < 18; i++) begin
            pix_valid = (i % 2 == 0); pix_data = DW'($urandom);
            tick();
        end
        pix_valid = 0;
        chk("gap_row", WW'(wr_row), WW'(3'd1));
        chk("gap_col", WW'(wr_col), WW'(3'd2));

        // 11 more beats to reach 20, then flush alongside beat 21
        for (int i = 0; i < 11; i++) begin
            pix_valid = 1; pix_data = DW'($urandom); tick();
        end
        flush = 1; pix_valid = 1; pix_data = 16'hdead; tick();
        flush = 0; pix_valid = 0;
        #1;
        chk("flush_row", WW'(wr_row), WW'(3'd0));
        chk("flush_col", WW'(wr_col), WW'(3'd0));
        chk("flush_idle_ready", WW'(pix_ready), WW'(1'b0));
        chk("flush_slot20_kept", WW'(win_data[20*DW +: DW]), WW'(16'd21));

        // reset mid-fill
        @(negedge clk);
        start = 1; tick(); start = 0;
        for (int i = 0; i < 30; i++) begin
            pix_valid = 1; pix_data = DW'($urandom | 1); tick();
        end
        pix_valid = 0;
        rst_n = 0;
        model_reset();
        tick();
        rst_n = 1;
        #1;
        chk("midfill_reset_data", win_data, '0);
        chk("midfill_reset_valid", WW'(win_valid), WW'(1'b0));
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            pix_valid = 1; pix_data = DW'($urandom); tick();
        end
        #1;
        chk("post_reset_ready", WW'(pix_ready), WW'(1'b0));
        @(negedge clk);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            start     = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 99) == 0);
            pix_valid = ($urandom_range(0, 3) != 0);
            win_ready = ($urandom_range(0, 3) == 0);
            pix_data  = DW'($urandom);
            tick();
        end
        set_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
